// File: rtl/game_step_responder.sv
// Responder for the game FSM's step bus: deals LFSR cards, times SHOW/WIN dwells,
// judges the guess and returns single-cycle handshake pulses.
//
// step | meaning
// 0000 | IDLE: clear round state (also any undefined code)
// 0001 | DEAL: draw one card RAND_LAT cycles after entry
// 0010 | SHOW: done after DISPLAY_CYCLES while cards remain
// 0011 | FULL: hold everything
// 0111 | CHECK: compare guess to target, win or finish
// 1000 | WIN: finish after WIN_HOLD_CYCLES
module game_step_responder #(
  parameter int          NUM_CARDS       = 8,
  parameter int          VAL_W           = 4,
  parameter int          RAND_LAT        = 4,
  parameter int          DISPLAY_CYCLES  = 25_000_000,
  parameter int          WIN_HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  localparam int         IDX_W           = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       step,
  input  logic [VAL_W-1:0] guess,
  output logic             rand_ready,
  output logic             done,
  output logic             win,
  output logic             finish,
  output logic [VAL_W-1:0] card_val,
  output logic [IDX_W-1:0] card_idx,
  output logic [VAL_W-1:0] target_val
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_DEAL  = 4'b0001,
    ST_SHOW  = 4'b0010,
    ST_FULL  = 4'b0011,
    ST_CHECK = 4'b0111,
    ST_WIN   = 4'b1000
  } step_e;

  localparam int               CNT_W      = $clog2(NUM_CARDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_CARDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(NUM_CARDS);
  localparam logic [31:0]      DEAL_LOAD  = 32'(RAND_LAT - 1);
  localparam logic [31:0]      SHOW_LOAD  = 32'(DISPLAY_CYCLES - 1);
  localparam logic [31:0]      WIN_LOAD   = 32'(WIN_HOLD_CYCLES - 1);
  localparam logic [31:0]      CHECK_LOAD = 32'd1;
  localparam logic [15:0]      LFSR_MASK  = 16'hB400;

  logic [3:0]       prev_step, prev_step_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [31:0]      tmr, tmr_nxt, load, cnt_now;
  logic             armed, armed_nxt, armed_now, entry, fire;
  logic [CNT_W-1:0] deal_cnt, deal_cnt_nxt;
  logic [VAL_W-1:0] card_val_nxt, target_val_nxt;
  logic [IDX_W-1:0] card_idx_nxt;
  logic             rand_ready_nxt, done_nxt, win_nxt, finish_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_step  <= ST_IDLE;
      lfsr       <= LFSR_SEED;
      tmr        <= '0;
      armed      <= 1'b0;
      deal_cnt   <= '0;
      card_val   <= '0;
      card_idx   <= '0;
      target_val <= '0;
      rand_ready <= 1'b0;
      done       <= 1'b0;
      win        <= 1'b0;
      finish     <= 1'b0;
    end else begin
      prev_step  <= prev_step_nxt;
      lfsr       <= lfsr_nxt;
      tmr        <= tmr_nxt;
      armed      <= armed_nxt;
      deal_cnt   <= deal_cnt_nxt;
      card_val   <= card_val_nxt;
      card_idx   <= card_idx_nxt;
      target_val <= target_val_nxt;
      rand_ready <= rand_ready_nxt;
      done       <= done_nxt;
      win        <= win_nxt;
      finish     <= finish_nxt;
    end
  end

  always_comb begin
    prev_step_nxt  = step;
    lfsr_nxt       = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    entry          = (step != prev_step);

    load = '0;
    case (step)
      ST_DEAL:  load = DEAL_LOAD;
      ST_SHOW:  load = SHOW_LOAD;
      ST_CHECK: load = CHECK_LOAD;
      ST_WIN:   load = WIN_LOAD;
      default:  load = '0;
    endcase

    // Registered pulses become visible one cycle after the decision, so the
    // timer fires while it still reads 1 (or 0 for a zero-length load).
    cnt_now   = entry ? load : tmr;
    armed_now = entry | armed;
    fire      = armed_now && (cnt_now <= 32'd1);

    tmr_nxt        = (cnt_now != '0) ? cnt_now - 32'd1 : '0;
    armed_nxt      = armed_now & ~fire;
    deal_cnt_nxt   = deal_cnt;
    card_val_nxt   = card_val;
    card_idx_nxt   = card_idx;
    target_val_nxt = target_val;
    rand_ready_nxt = 1'b0;
    done_nxt       = 1'b0;
    win_nxt        = 1'b0;
    finish_nxt     = 1'b0;

    case (step)
      ST_DEAL: begin
        if (fire && (deal_cnt < CNT_FULL)) begin
          card_val_nxt   = lfsr[VAL_W-1:0];
          card_idx_nxt   = deal_cnt[IDX_W-1:0];
          rand_ready_nxt = 1'b1;
          done_nxt       = (deal_cnt == CNT_LAST);
          deal_cnt_nxt   = deal_cnt + 1'b1;
          if (deal_cnt == '0) target_val_nxt = lfsr[VAL_W-1:0];
        end
      end
      ST_SHOW: begin
        if (fire && (deal_cnt < CNT_FULL)) done_nxt = 1'b1;
      end
      ST_FULL: begin
        tmr_nxt   = tmr;
        armed_nxt = armed;
      end
      ST_CHECK: begin
        if (fire) begin
          if (guess == target_val) win_nxt    = 1'b1;
          else                     finish_nxt = 1'b1;
        end
      end
      ST_WIN: begin
        if (fire) finish_nxt = 1'b1;
      end
      default: begin
        tmr_nxt        = '0;
        armed_nxt      = 1'b0;
        deal_cnt_nxt   = '0;
        card_val_nxt   = '0;
        card_idx_nxt   = '0;
        target_val_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_step_responder.sv
// Randomized bench for game_step_responder against an age-based reference model
// that counts cycles since each step entry and applies the dealing rules directly.
module tb_game_step_responder;

  localparam int NC = 8;
  localparam int VW = 4;
  localparam int RL = 4;
  localparam int DC = 10;
  localparam int WH = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    step = 4'b0000;
  logic [VW-1:0] guess = '0;
  logic          rand_ready, done, win, finish;
  logic [VW-1:0] card_val, target_val;
  logic [2:0]    card_idx;

  game_step_responder #(
    .NUM_CARDS(NC), .VAL_W(VW), .RAND_LAT(RL),
    .DISPLAY_CYCLES(DC), .WIN_HOLD_CYCLES(WH), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .guess(guess),
    .rand_ready(rand_ready), .done(done), .win(win), .finish(finish),
    .card_val(card_val), .card_idx(card_idx), .target_val(target_val)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pulses are visible in the Nth cycle of a step, i.e. after
  // the (N-1)th sampling edge (at least the first edge).
  logic [15:0]   m_lfsr;
  logic [3:0]    m_prev;
  int            m_age, m_cnt;
  logic [VW-1:0] e_card, e_target;
  logic [2:0]    e_idx;
  logic          e_rr, e_done, e_win, e_fin;

  function automatic int fire_at(input int lat);
    return (lat > 1) ? lat - 1 : 1;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_prev = 4'b0000; m_age = 0; m_cnt = 0;
    e_card = '0; e_target = '0; e_idx = '0;
    e_rr = 1'b0; e_done = 1'b0; e_win = 1'b0; e_fin = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] s, input logic [VW-1:0] g);
    m_age  = (s != m_prev) ? 1 : m_age + 1;
    m_prev = s;
    e_rr = 1'b0; e_done = 1'b0; e_win = 1'b0; e_fin = 1'b0;
    case (s)
      4'b0001: if (m_age == fire_at(RL) && m_cnt < NC) begin
        e_card = m_lfsr[VW-1:0];
        e_idx  = 3'(m_cnt);
        if (m_cnt == 0) e_target = e_card;
        e_rr   = 1'b1;
        e_done = (m_cnt == NC - 1);
        m_cnt++;
      end
      4'b0010: if (m_age == fire_at(DC) && m_cnt < NC) e_done = 1'b1;
      4'b0011: ;
      4'b0111: if (m_age == 1) begin
        e_win = (g == e_target);
        e_fin = (g != e_target);
      end
      4'b1000: if (m_age == fire_at(WH)) e_fin = 1'b1;
      default: begin
        m_cnt = 0; e_card = '0; e_idx = '0; e_target = '0;
      end
    endcase
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic check_outputs();
    check_eq("rand_ready", 32'(rand_ready), 32'(e_rr));
    check_eq("done",       32'(done),       32'(e_done));
    check_eq("win",        32'(win),        32'(e_win));
    check_eq("finish",     32'(finish),     32'(e_fin));
    check_eq("card_val",   32'(card_val),   32'(e_card));
    check_eq("card_idx",   32'(card_idx),   32'(e_idx));
    check_eq("target_val", 32'(target_val), 32'(e_target));
  endtask

  task automatic cyc(input logic [3:0] s, input logic [VW-1:0] g);
    step  = s;
    guess = g;
    model_edge(s, g);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input logic [3:0] s, input logic [VW-1:0] g, input int n);
    for (int i = 0; i < n; i++) cyc(s, g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step  = 4'b0000;
    #1;
    check_eq("rst_rand_ready", 32'(rand_ready), 32'd0);
    check_eq("rst_done",       32'(done),       32'd0);
    check_eq("rst_win",        32'(win),        32'd0);
    check_eq("rst_finish",     32'(finish),     32'd0);
    check_eq("rst_card_val",   32'(card_val),   32'd0);
    check_eq("rst_card_idx",   32'(card_idx),   32'd0);
    check_eq("rst_target_val", 32'(target_val), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]    s;
    logic [VW-1:0] g;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    run(4'h0, '0, 2);
    // first card of a round, then a full display dwell
    run(4'h1, '0, 6);
    run(4'h2, '0, 12);
    // reset with the DEAL timer part-way through; the reseeded draw is checked after
    run(4'h1, '0, 1);
    do_reset();
    run(4'h0, '0, 2);
    run(4'h1, '0, 5);

    // full round of eight cards alternating with SHOW, then an exhausted deck
    run(4'h0, '0, 1);
    for (int c = 0; c < NC; c++) begin
      run(4'h1, '0, 5);
      run(4'h2, '0, 12);
    end
    run(4'h1, '0, 5);
    run(4'h2, '0, 15);

    // correct guess, then the win dwell
    run(4'h7, e_target, 3);
    run(4'h8, '0, 22);
    // wrong guess
    run(4'h7, e_target ^ 4'h1, 3);
    run(4'h3, '0, 3);

    // SHOW abandoned half-way, then re-entered
    run(4'h0, '0, 1);
    run(4'h1, '0, 5);
    run(4'h2, '0, 5);
    run(4'h3, '0, 2);
    run(4'h2, '0, 12);

    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
      else                           s = codes[$urandom_range(0, 7)];
      g = ($urandom_range(0, 1) == 1) ? e_target : VW'($urandom_range(0, 15));
      run(s, g, $urandom_range(1, 24));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
